addr_reg_file: RTL
==================

ADDR_REG_FILE -- requirements
Module: addr_reg_file

Interface
REQ-001 Parameter DATA_W, default 8, width of each stored entry.
REQ-002 Parameter NUM_ENTRIES, default 15, number of storage entries; legal addresses 0..NUM_ENTRIES-1.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port Start  input  1  one-cycle pulse; invalidates all entries (new address-sequence run).
REQ-006 Port WriteEn  input  1  write strobe.
REQ-007 Port WriteReg  input  4  write address from address counter.
REQ-008 Port WriteData  input  DATA_W  write data.
REQ-009 Port ReadEn  input  1  read strobe, shared by all three read ports.
REQ-010 Port ReadReg1/ReadReg2/ReadReg3  input  4 each  read addresses.
REQ-011 Port ReadData1/ReadData2/ReadData3  output  DATA_W each  registered read data.
REQ-012 Port ReadValid  output  1  pulses high for the cycle after an accepted read.
REQ-013 Port ReadMiss  output  3  bit n-1 high when port n read an invalid entry or an illegal address.
REQ-014 Port EntryValid  output  NUM_ENTRIES  per-entry written-since-Start flags.
REQ-015 Port ValidCount  output  4  number of set EntryValid bits (0..15).
REQ-016 Port AddrErr  output  1  registered; high one cycle after any strobed access used address >= NUM_ENTRIES.

Function
REQ-017 Write: on edge with WriteEn=1 and WriteReg<NUM_ENTRIES, mem[WriteReg]<=WriteData and EntryValid[WriteReg]<=1.
REQ-018 Write with WriteReg>=NUM_ENTRIES: no storage change; AddrErr=1 next cycle.
REQ-019 Read: on edge with ReadEn=1, each ReadDataN<=mem[ReadRegN] if entry valid, else 0; latency exactly 1 cycle.
REQ-020 ReadValid=1 in the cycle following ReadEn=1, else 0; back-to-back ReadEn gives continuous ReadValid.
REQ-021 ReadEn=0: ReadDataN and ReadMiss hold previous values.
REQ-022 Illegal read address: ReadDataN<=0, ReadMiss bit set, AddrErr=1 next cycle.
REQ-023 Start=1: all EntryValid cleared; mem contents not cleared but masked by EntryValid.
REQ-024 Start and WriteEn same edge: Start applied first, then write; result EntryValid has only WriteReg bit set, ValidCount=1.
REQ-025 Start and ReadEn same edge: read uses pre-edge EntryValid and mem.
REQ-026 ValidCount increments only when writing a previously invalid entry; rewrite of valid entry leaves it unchanged; Start resets to 0 (or 1 per REQ-024).
REQ-027 Same-address write and read same edge: behaviour set by REQ-031/032.
REQ-028 Multiple read ports at same address return identical data.

Reset
REQ-029 rst=1 asynchronously forces: mem all 0, EntryValid=0, ValidCount=0, ReadData1..3=0, ReadValid=0, ReadMiss=0, AddrErr=0.
REQ-030 rst asserted mid-access discards the access; first accepted access is on the first edge after rst deasserts.

Configuration
REQ-031 With WRITE_BYPASS_EN defined: read of address equal to legal WriteReg in same cycle returns WriteData, ReadMiss bit 0.
REQ-032 Without WRITE_BYPASS_EN: such a read returns pre-write contents (0 with ReadMiss set if entry was invalid).

Structure
REQ-033 Package addr_rf_pkg holds ADDR_W=4, default NUM_ENTRIES=15, default DATA_W=8, and illegal-address constant 4'hF.
REQ-034 Sub-module addr_rf_read_port (address check, valid mask, optional bypass, output register) instantiated three times.

Verification
REQ-035 rst, then write 8'hA5 to addr 3 -> EntryValid=15'h0008, ValidCount=1.
REQ-036 ReadEn with ReadReg1=3, ReadReg2=4, ReadReg3=3 -> next cycle ReadData1=8'hA5, ReadData2=0, ReadData3=8'hA5, ReadMiss=3'b010, ReadValid=1.
REQ-037 Write 8'h3C to addr 3 while reading addr 3 -> 8'h3C with WRITE_BYPASS_EN, 8'hA5 without.
REQ-038 Write all 15 addresses, then Start with write of 8'h11 to addr 7 -> ValidCount=1, EntryValid=15'h0080; read addr 2 returns 0 with miss.
REQ-039 Write to addr 15 and read ReadReg2=15 -> no state change, ReadData2=0, ReadMiss[1]=1, AddrErr=1 one cycle.
REQ-040 Assert rst between ReadEn edge and next edge -> all outputs 0 immediately, ReadValid never asserts.

Source files
------------

// File: rtl/addr_rf_pkg.sv
// Shared constants and helpers for the address-sequence register file.
package addr_rf_pkg;

  localparam int ADDR_W          = 4;
  localparam int DEF_NUM_ENTRIES = 15;
  localparam int DEF_DATA_W      = 8;

  localparam logic [ADDR_W-1:0] ILLEGAL_ADDR = 4'hF;

  // Addresses at or beyond the entry count are illegal for both reads and writes.
  function automatic logic addr_legal(input logic [ADDR_W-1:0] addr, input int num_entries);
    return {1'b0, addr} < (ADDR_W+1)'(num_entries);
  endfunction

endpackage

// File: rtl/addr_rf_read_port.sv
// One registered read port: address check, valid masking, optional same-cycle write bypass.
// Build option: WRITE_BYPASS_EN forwards a same-address legal write to the read result.
module addr_rf_read_port
  import addr_rf_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int NUM_ENTRIES = DEF_NUM_ENTRIES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] mem [NUM_ENTRIES],
  input  logic [NUM_ENTRIES-1:0] entry_valid,
  input  logic              wr_ok,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_miss
);

  logic              legal;
  logic              byp_hit;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] data_next, data_reg;
  logic              miss_next, miss_reg;

`ifdef WRITE_BYPASS_EN
  assign byp_hit = wr_ok && (wr_addr == rd_addr);
`else
  assign byp_hit = 1'b0;
  logic unused_wr;
  assign unused_wr = ^{wr_ok, wr_addr};
`endif

  always_comb begin
    legal     = addr_legal(rd_addr, NUM_ENTRIES);
    idx       = legal ? rd_addr : '0;
    data_next = '0;
    miss_next = 1'b1;
    if (byp_hit) begin
      data_next = wr_data;
      miss_next = 1'b0;
    end else if (legal && entry_valid[idx]) begin
      data_next = mem[idx];
      miss_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg <= '0;
      miss_reg <= 1'b0;
    end else if (rd_en) begin
      data_reg <= data_next;
      miss_reg <= miss_next;
    end
  end

  assign rd_data = data_reg;
  assign rd_miss = miss_reg;

endmodule

// File: rtl/addr_reg_file.sv
// Register file with per-entry valid flags cleared by Start, three shared-strobe read ports.
// Build option: WRITE_BYPASS_EN enables same-cycle write-to-read forwarding.
module addr_reg_file
  import addr_rf_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int NUM_ENTRIES = DEF_NUM_ENTRIES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   Start,
  input  logic                   WriteEn,
  input  logic [ADDR_W-1:0]      WriteReg,
  input  logic [DATA_W-1:0]      WriteData,
  input  logic                   ReadEn,
  input  logic [ADDR_W-1:0]      ReadReg1,
  input  logic [ADDR_W-1:0]      ReadReg2,
  input  logic [ADDR_W-1:0]      ReadReg3,
  output logic [DATA_W-1:0]      ReadData1,
  output logic [DATA_W-1:0]      ReadData2,
  output logic [DATA_W-1:0]      ReadData3,
  output logic                   ReadValid,
  output logic [2:0]             ReadMiss,
  output logic [NUM_ENTRIES-1:0] EntryValid,
  output logic [3:0]             ValidCount,
  output logic                   AddrErr
);

  logic [DATA_W-1:0]      mem_reg [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] valid_reg;
  logic [3:0]             count_reg, count_next;
  logic                   read_valid_reg, addr_err_reg, addr_err_next;
  logic                   wr_ok;
  logic [ADDR_W-1:0]      rd_addr [3];
  logic [DATA_W-1:0]      rd_data [3];
  logic [2:0]             rd_bad, rd_miss;

  assign wr_ok      = WriteEn && addr_legal(WriteReg, NUM_ENTRIES);
  assign rd_addr[0] = ReadReg1;
  assign rd_addr[1] = ReadReg2;
  assign rd_addr[2] = ReadReg3;

  // Start clears the flag first so a same-edge write leaves exactly its own entry valid.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mem_reg[gi]   <= '0;
          valid_reg[gi] <= 1'b0;
        end else begin
          if (Start)
            valid_reg[gi] <= 1'b0;
          if (wr_ok && (WriteReg == ADDR_W'(gi))) begin
            mem_reg[gi]   <= WriteData;
            valid_reg[gi] <= 1'b1;
          end
        end
      end
    end

    for (gi = 0; gi < 3; gi++) begin : g_rd
      assign rd_bad[gi] = !addr_legal(rd_addr[gi], NUM_ENTRIES);

      addr_rf_read_port #(
        .DATA_W      (DATA_W),
        .NUM_ENTRIES (NUM_ENTRIES)
      ) u_port (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (ReadEn),
        .rd_addr     (rd_addr[gi]),
        .mem         (mem_reg),
        .entry_valid (valid_reg),
        .wr_ok       (wr_ok),
        .wr_addr     (WriteReg),
        .wr_data     (WriteData),
        .rd_data     (rd_data[gi]),
        .rd_miss     (rd_miss[gi])
      );
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    if (Start)
      count_next = wr_ok ? 4'd1 : 4'd0;
    else if (wr_ok && !valid_reg[WriteReg])
      count_next = count_reg + 4'd1;
    addr_err_next = (WriteEn && !addr_legal(WriteReg, NUM_ENTRIES)) || (ReadEn && (|rd_bad));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg      <= '0;
      read_valid_reg <= 1'b0;
      addr_err_reg   <= 1'b0;
    end else begin
      count_reg      <= count_next;
      read_valid_reg <= ReadEn;
      addr_err_reg   <= addr_err_next;
    end
  end

  assign ReadData1  = rd_data[0];
  assign ReadData2  = rd_data[1];
  assign ReadData3  = rd_data[2];
  assign ReadMiss   = rd_miss;
  assign ReadValid  = read_valid_reg;
  assign EntryValid = valid_reg;
  assign ValidCount = count_reg;
  assign AddrErr    = addr_err_reg;

endmodule
